// File: rtl/vxe_vpu_pkg.sv
// Shared VPU product-EU definitions: FSM encoding, request tags, address widths
// and the agen lane-mask helper.
package vxe_vpu_pkg;

  localparam int VA_W = 38;
  localparam int WA_W = 37;
  localparam int VL_W = 20;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LAT_A = 3'd1;
  localparam logic [2:0] ST_LAT_B = 3'd2;
  localparam logic [2:0] ST_SETL  = 3'd3;
  localparam logic [2:0] ST_FETCH = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  // Lanes of the current 64-bit word: [0] = even element, [1] = odd element.
  function automatic logic [1:0] lane_mask(input logic odd, input logic [VL_W-1:0] rem);
    if (rem == '0)
      return 2'b00;
    if (odd)
      return 2'b10;
    if (rem == VL_W'(1))
      return 2'b01;
    return 2'b11;
  endfunction

endpackage

// File: rtl/vxe_vpu_prod_eu_fetch_ctl_if.sv
// Memory request port of the fetch sequencer (master = sequencer, slave = arbiter).
interface vxe_vpu_prod_eu_fetch_ctl_if;
  import vxe_vpu_pkg::*;

  logic            rq_vld;
  logic [WA_W-1:0] rq_addr;
  logic [1:0]      rq_mask;
  logic            rq_tag;
  logic            rq_rdy;

  modport master (output rq_vld, rq_addr, rq_mask, rq_tag, input rq_rdy);
  modport slave  (input rq_vld, rq_addr, rq_mask, rq_tag, output rq_rdy);
endinterface

// File: rtl/vxe_vpu_credit_cnt.sv
// Saturating credit counter for operand FIFO slots; resets to full.
module vxe_vpu_credit_cnt #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_empty,
  output logic o_full
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == FULL);

  // A return and a consume in the same cycle cancel; a return at full is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && !i_dec && !o_full)
      cnt_d = cnt_q + CW'(1);
    else if (i_dec && !i_inc && !o_empty)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= FULL;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vxe_vpu_prod_eu_agen.sv
// Vector address generator: walks 32-bit elements two per 64-bit word from a latched base.
module vxe_vpu_prod_eu_agen
  import vxe_vpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_latch,
  input  logic [VA_W-1:0] i_vaddr,
  input  logic [VL_W-1:0] i_vlen,
  input  logic            i_incr,
  output logic            o_valid,
  output logic [WA_W-1:0] o_addr,
  output logic [1:0]      o_mask
);

  logic [VA_W-1:0] cur_q;
  logic [VL_W-1:0] rem_q;
  logic [1:0]      step;

  assign o_valid = (rem_q != '0);
  assign o_addr  = cur_q[VA_W-1:1];
  assign o_mask  = lane_mask(cur_q[0], rem_q);
  assign step    = (o_mask == 2'b11) ? 2'd2 : 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      rem_q <= '0;
    end else if (i_latch) begin
      cur_q <= i_vaddr;
      rem_q <= i_vlen;
    end else if (i_incr && o_valid) begin
      cur_q <= cur_q + VA_W'(step);
      rem_q <= rem_q - VL_W'(step);
    end
  end

endmodule

// File: rtl/vxe_vpu_prod_eu_fetch_ctl.sv
// Fetch sequencer: loads agens A/B, then round-robins their words onto one credited request port.
// Build macro VXE_VPU_FETCH_STALL_CNT_EN adds the o_stall_cnt port and counter.
//   state | meaning
//   IDLE  | waiting for i_start
//   LAT_A | agen A latches base A
//   LAT_B | agen B latches base B
//   SETL  | agen outputs settle
//   FETCH | issuing requests while either agen is valid
//   DRAIN | waiting for all credits to return, then done
module vxe_vpu_prod_eu_fetch_ctl
  import vxe_vpu_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [VA_W-1:0]                    i_vaddr_a,
  input  logic [VA_W-1:0]                    i_vaddr_b,
  input  logic [VL_W-1:0]                    i_vlen,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [VA_W-1:0]                    o_ag_vaddr,
  output logic [VL_W-1:0]                    o_ag_vlen,
  output logic [1:0]                         o_ag_latch,
  output logic [1:0]                         o_ag_incr,
  input  logic [1:0]                         i_ag_valid,
  input  logic [WA_W-1:0]                    i_ag_addr_a,
  input  logic [WA_W-1:0]                    i_ag_addr_b,
  input  logic [1:0]                         i_ag_mask_a,
  input  logic [1:0]                         i_ag_mask_b,
  vxe_vpu_prod_eu_fetch_ctl_if.master        rq,
  input  logic                               i_cr_ret
`ifdef VXE_VPU_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]                        o_stall_cnt
`endif
);

  logic [2:0]      state_q, state_d;
  logic            rr_q, rr_d;
  logic [VA_W-1:0] ag_vaddr_q, vaddr_b_q;
  logic [VL_W-1:0] ag_vlen_q;
  logic            start_ok, fetch, cand_tag, cand_vld, accept;
  logic            cr_empty, cr_full;

  assign start_ok = (state_q == ST_IDLE) && i_start;
  assign fetch    = (state_q == ST_FETCH);

  // Prefer the round-robin side; fall back to the other side when it has nothing.
  always_comb begin
    if (rr_q == TAG_B)
      cand_tag = i_ag_valid[1] ? TAG_B : TAG_A;
    else
      cand_tag = i_ag_valid[0] ? TAG_A : TAG_B;
  end

  assign cand_vld   = (cand_tag == TAG_B) ? i_ag_valid[1] : i_ag_valid[0];
  assign rq.rq_vld  = fetch && cand_vld && !cr_empty;
  assign rq.rq_addr = !fetch ? '0 : (cand_tag == TAG_B) ? i_ag_addr_b : i_ag_addr_a;
  assign rq.rq_mask = !fetch ? '0 : (cand_tag == TAG_B) ? i_ag_mask_b : i_ag_mask_a;
  assign rq.rq_tag  = fetch && (cand_tag == TAG_B);
  assign accept     = rq.rq_vld && rq.rq_rdy;

  assign o_ag_incr  = {accept && (cand_tag == TAG_B), accept && (cand_tag == TAG_A)};
  assign o_ag_latch = {state_q == ST_LAT_B, state_q == ST_LAT_A};
  assign o_ag_vaddr = ag_vaddr_q;
  assign o_ag_vlen  = ag_vlen_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DRAIN) && cr_full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = (i_vlen == '0) ? ST_DRAIN : ST_LAT_A;
      ST_LAT_A: state_d = ST_LAT_B;
      ST_LAT_B: state_d = ST_SETL;
      ST_SETL:  state_d = ST_FETCH;
      ST_FETCH: if (i_ag_valid == 2'b00) state_d = ST_DRAIN;
      ST_DRAIN: if (cr_full) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (start_ok)
      rr_d = TAG_A;
    else if (accept)
      rr_d = ~cand_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= TAG_A;
      ag_vaddr_q <= '0;
      vaddr_b_q  <= '0;
      ag_vlen_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (start_ok) begin
        ag_vaddr_q <= i_vaddr_a;
        vaddr_b_q  <= i_vaddr_b;
        ag_vlen_q  <= i_vlen;
      end else if (state_q == ST_LAT_A) begin
        ag_vaddr_q <= vaddr_b_q;
      end
    end
  end

  vxe_vpu_credit_cnt #(.CREDITS(CREDITS), .CW(CW)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (i_cr_ret),
    .i_dec   (accept),
    .o_empty (cr_empty),
    .o_full  (cr_full)
  );

`ifdef VXE_VPU_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (start_ok)
      stall_cnt_q <= '0;
    else if (fetch && cand_vld && (cr_empty || !rq.rq_rdy))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vxe_vpu_prod_eu_fetch_ctl.sv
// Scoreboard bench for the fetch sequencer driving two real agens.
module tb_vxe_vpu_prod_eu_fetch_ctl;
  import vxe_vpu_pkg::*;

  localparam int CREDITS = 4;

  typedef struct packed {
    logic [WA_W-1:0] addr;
    logic [1:0]      mask;
    logic            tag;
  } rq_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [VA_W-1:0] vaddr_a, vaddr_b, ag_vaddr;
  logic [VL_W-1:0] vlen, ag_vlen;
  logic            busy, done;
  logic [1:0]      ag_latch, ag_incr, ag_valid, ag_mask_a, ag_mask_b;
  logic            ag_valid_a, ag_valid_b;
  logic [WA_W-1:0] ag_addr_a, ag_addr_b;
  logic            cr_man, cr_auto, cr_ret;
  logic [2:0]      ret_sr;
`ifdef VXE_VPU_FETCH_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  rq_t sb_q[$];
  int  n_cmp = 0, n_err = 0, acc_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  assign ag_valid = {ag_valid_b, ag_valid_a};
  assign cr_ret   = ret_sr[2] | cr_man;

  vxe_vpu_prod_eu_fetch_ctl_if rq_if ();

  vxe_vpu_prod_eu_fetch_ctl #(.CREDITS(CREDITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_vaddr_a   (vaddr_a),
    .i_vaddr_b   (vaddr_b),
    .i_vlen      (vlen),
    .o_busy      (busy),
    .o_done      (done),
    .o_ag_vaddr  (ag_vaddr),
    .o_ag_vlen   (ag_vlen),
    .o_ag_latch  (ag_latch),
    .o_ag_incr   (ag_incr),
    .i_ag_valid  (ag_valid),
    .i_ag_addr_a (ag_addr_a),
    .i_ag_addr_b (ag_addr_b),
    .i_ag_mask_a (ag_mask_a),
    .i_ag_mask_b (ag_mask_b),
    .rq          (rq_if),
    .i_cr_ret    (cr_ret)
`ifdef VXE_VPU_FETCH_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  vxe_vpu_prod_eu_agen u_agen_a (
    .clk (clk), .rst (rst), .i_latch (ag_latch[0]), .i_vaddr (ag_vaddr), .i_vlen (ag_vlen),
    .i_incr (ag_incr[0]), .o_valid (ag_valid_a), .o_addr (ag_addr_a), .o_mask (ag_mask_a)
  );

  vxe_vpu_prod_eu_agen u_agen_b (
    .clk (clk), .rst (rst), .i_latch (ag_latch[1]), .i_vaddr (ag_vaddr), .i_vlen (ag_vlen),
    .i_incr (ag_incr[1]), .o_valid (ag_valid_b), .o_addr (ag_addr_b), .o_mask (ag_mask_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [WA_W-1:0] a, input logic [1:0] m, input logic t);
    rq_t e;
    e.addr = a;
    e.mask = m;
    e.tag  = t;
    sb_q.push_back(e);
  endtask

  // A/B interleave for aligned bases: nw full words per side.
  task automatic push_ab(input logic [WA_W-1:0] a, input logic [WA_W-1:0] b, input int nw);
    for (int i = 0; i < nw; i++) begin
      push(a + WA_W'(i), 2'b11, TAG_A);
      push(b + WA_W'(i), 2'b11, TAG_B);
    end
  endtask

  task automatic do_start(input logic [VA_W-1:0] a, input logic [VA_W-1:0] b, input logic [VL_W-1:0] l);
    @(posedge clk); #1;
    vaddr_a = a;
    vaddr_b = b;
    vlen    = l;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
    @(negedge clk);
    chk({name, "_done_pulses"}, 64'(done_cnt), 64'(d0 + 1));
    chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
    chk({name, "_idle_after"}, 64'(busy), 64'(0));
  endtask

  task automatic pulse_ret();
    @(posedge clk); #1 cr_man = 1'b1;
    @(posedge clk); #1 cr_man = 1'b0;
  endtask

  // Monitor: pops one expected request per accepted transfer.
  initial begin : monitor
    rq_t e;
    logic acc;
    forever begin
      @(negedge clk);
      acc = rq_if.rq_vld & rq_if.rq_rdy;
      if (acc) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req: got addr 0x%0h tag %0d, expected no request", rq_if.rq_addr, rq_if.rq_tag);
        end else begin
          e = sb_q.pop_front();
          chk("rq_addr", 64'(rq_if.rq_addr), 64'(e.addr));
          chk("rq_mask", 64'(rq_if.rq_mask), 64'(e.mask));
          chk("rq_tag", 64'(rq_if.rq_tag), 64'(e.tag));
          chk("ag_incr_acc", 64'(ag_incr), (e.tag == TAG_B) ? 64'(2) : 64'(1));
        end
      end else begin
        chk("ag_incr_idle", 64'(ag_incr), 64'(0));
      end
      if (done) done_cnt++;
      ret_sr = {ret_sr[1:0], acc & cr_auto};
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int d0, a0;
    logic [WA_W-1:0] h_addr;
    logic [1:0]      h_mask;
    logic            h_tag;
    rst = 1'b1; start = 1'b0; vaddr_a = '0; vaddr_b = '0; vlen = '0;
    cr_man = 1'b0; cr_auto = 1'b1; ret_sr = '0; rq_if.rq_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rq_vld", 64'(rq_if.rq_vld), 64'(0));
    chk("rst_rq_addr", 64'(rq_if.rq_addr), 64'(0));
    chk("rst_latch", 64'(ag_latch), 64'(0));
    chk("rst_ag_vaddr", 64'(ag_vaddr), 64'(0));
    chk("rst_ag_vlen", 64'(ag_vlen), 64'(0));

    // T1: single element per side
    push(37'h80, 2'b01, TAG_A);
    push(37'h100, 2'b01, TAG_B);
    d0 = done_cnt;
    do_start(38'h100, 38'h200, 20'd1);
    @(negedge clk);
    chk("t1_latch_a", 64'(ag_latch), 64'(1));
    chk("t1_vaddr_a", 64'(ag_vaddr), 64'h100);
    chk("t1_vlen", 64'(ag_vlen), 64'(1));
    chk("t1_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("t1_latch_b", 64'(ag_latch), 64'(2));
    chk("t1_vaddr_b", 64'(ag_vaddr), 64'h200);
    wait_done("t1", d0);

    // T2: eight elements, alternating full words
    push_ab(37'h80, 37'h100, 4);
    d0 = done_cnt;
    do_start(38'h100, 38'h200, 20'd8);
    wait_done("t2", d0);

    // T3: credit limit with no returns, then manual returns
    cr_auto = 1'b0;
    push_ab(37'h80, 37'h100, 4);
    a0 = acc_cnt;
    d0 = done_cnt;
    do_start(38'h100, 38'h200, 20'd8);
    repeat (40) @(negedge clk);
    chk("t3_accepts_at_limit", 64'(acc_cnt - a0), 64'(CREDITS));
    chk("t3_vld_blocked", 64'(rq_if.rq_vld), 64'(0));
    pulse_ret();
    repeat (10) @(negedge clk);
    chk("t3_one_more", 64'(acc_cnt - a0), 64'(CREDITS + 1));
    for (int i = 0; i < 7; i++) begin
      pulse_ret();
      @(posedge clk);
    end
    wait_done("t3", d0);
    pulse_ret();
    pulse_ret();
    @(negedge clk);
    chk("t3_credit_saturate", 64'(dut.u_credit.cnt_q), 64'(CREDITS));
    cr_auto = 1'b1;

    // T4: unaligned A base
    push(37'h80, 2'b10, TAG_A);
    push(37'h100, 2'b11, TAG_B);
    push(37'h81, 2'b11, TAG_A);
    push(37'h101, 2'b01, TAG_B);
    d0 = done_cnt;
    do_start(38'h101, 38'h200, 20'd3);
    wait_done("t4", d0);

    // T5: five cycles of backpressure
    rq_if.rq_rdy = 1'b0;
    push_ab(37'h80, 37'h100, 2);
    d0 = done_cnt;
    do_start(38'h100, 38'h200, 20'd4);
    for (int k = 0; k < 20 && !rq_if.rq_vld; k++) @(negedge clk);
    chk("t5_vld_seen", 64'(rq_if.rq_vld), 64'(1));
    h_addr = rq_if.rq_addr;
    h_mask = rq_if.rq_mask;
    h_tag  = rq_if.rq_tag;
    chk("t5_hold_addr0", 64'(h_addr), 64'h80);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_stable_vld", 64'(rq_if.rq_vld), 64'(1));
      chk("t5_stable_addr", 64'(rq_if.rq_addr), 64'(h_addr));
      chk("t5_stable_mask", 64'(rq_if.rq_mask), 64'(h_mask));
      chk("t5_stable_tag", 64'(rq_if.rq_tag), 64'(h_tag));
    end
    @(posedge clk); #1 rq_if.rq_rdy = 1'b1;
    wait_done("t5", d0);
`ifdef VXE_VPU_FETCH_STALL_CNT_EN
    repeat (3) @(negedge clk);
    chk("t5_stall_cnt", 64'(stall_cnt), 64'(5));
`endif

    // T6: reset mid-fetch with two credits outstanding
    cr_auto = 1'b0;
    push_ab(37'h80, 37'h100, 4);
    a0 = acc_cnt;
    do_start(38'h100, 38'h200, 20'd8);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      if (acc_cnt >= a0 + 2) break;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_accepts_before_rst", 64'(acc_cnt - a0), 64'(2));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_vld", 64'(rq_if.rq_vld), 64'(0));
    chk("t6_rst_credits", 64'(dut.u_credit.cnt_q), 64'(CREDITS));
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    cr_auto = 1'b1;

    push(37'h80, 2'b11, TAG_A);
    push(37'h100, 2'b11, TAG_B);
    push(37'h81, 2'b01, TAG_A);
    push(37'h101, 2'b01, TAG_B);
    d0 = done_cnt;
    do_start(38'h100, 38'h200, 20'd3);
    wait_done("t6_restart", d0);

    a0 = acc_cnt;
    d0 = done_cnt;
    do_start(38'h300, 38'h400, 20'd0);
    @(negedge clk);
    chk("t6_vlen0_busy", 64'(busy), 64'(1));
    chk("t6_vlen0_done", 64'(done), 64'(1));
    chk("t6_vlen0_latch", 64'(ag_latch), 64'(0));
    @(negedge clk);
    chk("t6_vlen0_idle", 64'(busy), 64'(0));
    chk("t6_vlen0_done_off", 64'(done), 64'(0));
    chk("t6_vlen0_no_req", 64'(acc_cnt - a0), 64'(0));
    chk("t6_vlen0_one_done", 64'(done_cnt - d0), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
